// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared definitions for the UART transmit drain stage.
// Holds the FSM state encoding, the parity-type constants and the default
// widths used by uart_tx_fifo_drain and uart_tx_bit_timer.
package uart_tx_fifo_drain_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_PRESC_W = 6;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period counter for the UART transmitter.
// Ports:
//   CLK, RST  clock and synchronous active-high reset
//   load      restart the period at count 0 (asserted on every state change)
//   presc     captured bit period P in CLK cycles, always >= 1
//   bit_end   high in the last cycle of the current bit (count == P-1)
module uart_tx_bit_timer
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int presc_width = DEF_PRESC_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   load,
  input  logic [presc_width-1:0] presc,
  output logic                   bit_end
);

  logic [presc_width-1:0] cnt;

  assign bit_end = (cnt == presc - presc_width'(1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (load || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + presc_width'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmit stage draining an async FIFO read port (TX clock domain).
// Pops a word whenever the FIFO is non-empty and the line is idle or in the
// final cycle of a stop bit, then sends start, data (LSB first), optional
// parity and stop bits, each lasting the prescale captured at pop time.
// Ports:
//   CLK, RST     clock and synchronous active-high reset
//   fifo_empty   FIFO empty flag (synchronised to CLK)
//   fifo_data    FIFO read data
//   fifo_rinc    combinational one-cycle pop pulse
//   par_en       append parity bit; par_typ selects even (0) / odd (1)
//   prescale     CLK cycles per bit, 0 behaves as 1
//   tx_out       serial line, idles high
//   busy         registered, high while a frame is in progress
//   frame_done   pulse in the last cycle of each stop bit
module uart_tx_fifo_drain
  import uart_tx_fifo_drain_pkg::*;
#(
  parameter int data_width  = DEF_DATA_W,
  parameter int presc_width = DEF_PRESC_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   fifo_empty,
  input  logic [data_width-1:0]  fifo_data,
  output logic                   fifo_rinc,
  input  logic                   par_en,
  input  logic                   par_typ,
  input  logic [presc_width-1:0] prescale,
  output logic                   tx_out,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int IDX_W = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(data_width - 1);

  function automatic logic [presc_width-1:0] clamp_presc(input logic [presc_width-1:0] p);
    return (p == '0) ? presc_width'(1) : p;
  endfunction

  function automatic logic calc_parity(input logic [data_width-1:0] d, input logic typ);
    logic r;
    case (typ)
      PAR_EVEN: r = ^d;
      PAR_ODD:  r = ~(^d);
      default:  r = ^d;
    endcase
    return r;
  endfunction

  tx_state_t              state, state_next;
  logic [data_width-1:0]  shift_q;
  logic [IDX_W-1:0]       bit_idx;
  logic                   par_en_q;
  logic                   par_bit_q;
  logic [presc_width-1:0] presc_q;
  logic                   busy_q;
  logic                   bit_end;
  logic                   pop;
  logic                   tx_bit;
  logic                   frame_end;
  logic                   timer_load;

  // Counter restarts on every state change; holding it in load while idle
  // keeps it at 0 so the first bit of a frame always gets a full period.
  assign timer_load = (state_next != state) || (state == IDLE);

  uart_tx_bit_timer #(
    .presc_width (presc_width)
  ) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .load    (timer_load),
    .presc   (presc_q),
    .bit_end (bit_end)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    tx_bit     = 1'b1;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !RST) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        tx_bit = shift_q[0];
        if (bit_end && (bit_idx == LAST_IDX)) begin
          state_next = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx_bit = par_bit_q;
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          frame_end = 1'b1;
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty && !RST) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fifo_rinc  = pop;
  assign tx_out     = tx_bit;
  assign frame_done = frame_end;
  assign busy       = busy_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      bit_idx  <= '0;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
      presc_q  <= presc_width'(1);
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
      if (pop) begin
        par_en_q <= par_en;
        presc_q  <= clamp_presc(prescale);
      end
      if ((state == DATA) && bit_end) begin
        bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + IDX_W'(1);
      end else if (state != DATA) begin
        bit_idx <= '0;
      end
    end
  end

  // Parity is fixed at pop time so the shift register can be consumed.
  always_ff @(posedge CLK) begin
    if (pop) begin
      shift_q   <= fifo_data;
      par_bit_q <= calc_parity(fifo_data, par_typ);
    end else if ((state == DATA) && bit_end) begin
      shift_q <= shift_q >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
module tb_uart_tx_fifo_drain;

  logic       CLK;
  logic       RST;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rinc;
  logic       par_en;
  logic       par_typ;
  logic [5:0] prescale;
  logic       tx_out;
  logic       busy;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_drain #(.data_width(8), .presc_width(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rinc  (fifo_rinc),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Bench-side FIFO contents
  logic [7:0] fifo_q[$];
  logic       do_pop = 1'b0;
  int         rinc_count = 0;

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    refresh_fifo();
  endtask

  always @(posedge CLK) begin
    if (do_pop) begin
      #1;
      if (fifo_q.size() != 0) fifo_q.delete(0);
      refresh_fifo();
    end
  end

  // Frame-level model: a queue of the line level expected on each coming cycle
  bit exp_q[$];

  always @(negedge CLK) begin : cmp
    logic       e_tx, e_busy, e_done, e_pop;
    logic [7:0] d;
    int         p;
    if (fifo_rinc === 1'b1) rinc_count++;
    if (RST) begin
      chk("rinc_in_reset", {31'd0, fifo_rinc}, 32'd0);
      exp_q.delete();
      do_pop = 1'b0;
    end else begin
      e_pop  = !fifo_empty && (exp_q.size() <= 1);
      e_tx   = (exp_q.size() != 0) ? exp_q[0] : 1'b1;
      e_busy = (exp_q.size() != 0);
      e_done = (exp_q.size() == 1);
      chk("tx_out",     {31'd0, tx_out},     {31'd0, e_tx});
      chk("busy",       {31'd0, busy},       {31'd0, e_busy});
      chk("frame_done", {31'd0, frame_done}, {31'd0, e_done});
      chk("fifo_rinc",  {31'd0, fifo_rinc},  {31'd0, e_pop});
      if (exp_q.size() != 0) exp_q.delete(0);
      if (e_pop) begin
        d = fifo_data;
        p = (prescale == 0) ? 1 : int'(prescale);
        for (int k = 0; k < p; k++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
          for (int k = 0; k < p; k++) exp_q.push_back(d[i]);
        if (par_en)
          for (int k = 0; k < p; k++) exp_q.push_back((^d) ^ par_typ);
        for (int k = 0; k < p; k++) exp_q.push_back(1'b1);
      end
      do_pop = e_pop;
    end
  end

  // Frame capture helpers for the literal checks
  logic log_tx [0:255];
  int   log_len;
  logic log_rinc_at_done;

  task automatic wait_pop();
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (fifo_rinc !== 1'b1 && n < 100);
    if (fifo_rinc !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout: got no fifo_rinc within %0d cycles, required one", n);
    end
  endtask

  task automatic record_frame();
    int  n;
    logic seen;
    n = 0;
    seen = 1'b0;
    log_rinc_at_done = 1'b0;
    while (!seen && n < 256) begin
      @(negedge CLK);
      log_tx[n] = tx_out;
      if (frame_done === 1'b1) begin
        seen = 1'b1;
        log_rinc_at_done = fifo_rinc;
      end
      n++;
    end
    log_len = n;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no frame_done within %0d cycles, required one", n);
    end
  endtask

  function automatic logic [7:0] data_bits(input int first, input int step);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = log_tx[first + i * step];
    return r;
  endfunction

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got simulation still running, required completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    int         rc0;
    logic [10:0] bits11;
    logic [10:0] exp11;
    logic       idle_ok;
    RST      = 1'b1;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    prescale = 6'd1;
    refresh_fifo();
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset state and idle line
    chk("reset_tx",   {31'd0, tx_out},    32'd1);
    chk("reset_busy", {31'd0, busy},      32'd0);
    chk("reset_rinc", {31'd0, fifo_rinc}, 32'd0);
    idle_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (tx_out !== 1'b1 || busy !== 1'b0 || fifo_rinc !== 1'b0) idle_ok = 1'b0;
    end
    chk("idle_20_cycles", {31'd0, idle_ok}, 32'd1);

    // 0xA5, prescale 1, even parity
    @(posedge CLK); #1;
    prescale = 6'd1; par_en = 1'b1; par_typ = 1'b0;
    rc0 = rinc_count;
    push(8'hA5);
    wait_pop();
    record_frame();
    for (int i = 0; i < 11; i++) bits11[i] = log_tx[i];
    exp11 = 11'b10101001010;
    chk("a5_len",  log_len, 32'd11);
    chk("a5_bits", {21'd0, bits11}, {21'd0, exp11});
    @(negedge CLK);
    chk("a5_single_pop", rinc_count - rc0, 32'd1);

    // 0x3C, prescale 4, no parity
    @(posedge CLK); #1;
    prescale = 6'd4; par_en = 1'b0;
    push(8'h3C);
    wait_pop();
    record_frame();
    chk("3c_len",   log_len, 32'd40);
    chk("3c_data",  {24'd0, data_bits(4, 4)}, 32'h3C);
    chk("3c_hold",  {24'd0, data_bits(7, 4)}, 32'h3C);
    chk("3c_start", {31'd0, log_tx[3]},  32'd0);
    chk("3c_stop",  {31'd0, log_tx[36]}, 32'd1);

    // Back-to-back: 0x01 even, then 0xFF odd, prescale 2
    @(posedge CLK); #1;
    prescale = 6'd2; par_en = 1'b1; par_typ = 1'b0;
    push(8'h01);
    push(8'hFF);
    wait_pop();
    @(posedge CLK); #1;
    par_typ = 1'b1;
    record_frame();
    chk("b2b_len1",        log_len, 32'd22);
    chk("b2b_par1",        {31'd0, log_tx[18]}, 32'd1);
    chk("b2b_pop_at_done", {31'd0, log_rinc_at_done}, 32'd1);
    record_frame();
    chk("b2b_no_gap",  {31'd0, log_tx[0]},  32'd0);
    chk("b2b_len2",    log_len, 32'd22);
    chk("b2b_data2",   {24'd0, data_bits(2, 2)}, 32'hFF);
    chk("b2b_par2",    {31'd0, log_tx[18]}, 32'd1);

    // Reset during data bit 3
    @(posedge CLK); #1;
    prescale = 6'd1; par_en = 1'b0; par_typ = 1'b0;
    push(8'hC3);
    wait_pop();
    repeat (5) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    chk("abort_tx",   {31'd0, tx_out}, 32'd1);
    chk("abort_busy", {31'd0, busy},   32'd0);
    @(posedge CLK); #1;
    par_en = 1'b1;
    push(8'h96);
    wait_pop();
    record_frame();
    chk("fresh_len",  log_len, 32'd11);
    chk("fresh_data", {24'd0, data_bits(1, 1)}, 32'h96);
    chk("fresh_par",  {31'd0, log_tx[9]}, 32'd0);

    // prescale 0 acts as 1; parity fixed at pop despite par_typ change
    @(posedge CLK); #1;
    prescale = 6'd0; par_en = 1'b1; par_typ = 1'b1;
    push(8'h0F);
    wait_pop();
    @(posedge CLK); #1;
    par_typ = 1'b0;
    record_frame();
    chk("p0_len",  log_len, 32'd11);
    chk("p0_data", {24'd0, data_bits(1, 1)}, 32'h0F);
    chk("p0_par",  {31'd0, log_tx[9]}, 32'd1);

    repeat (5) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
# uart_tx_fifo_drain

Single-clock UART transmit stage that sits directly downstream of the asynchronous FIFO's read side, in the UART TX clock domain. It watches the FIFO empty flag and pops one word with a one-cycle read-increment pulse. It then serialises that word as an 8N1/8E1/8O1-style frame on a single line, with a programmable bit period. Back-to-back words are sent with no idle gap.

## Interface
Parameters:
- data_width, 8, width of a FIFO word and number of data bits per frame
- presc_width, 6, width of the bit-period configuration input

Ports:
- CLK  in  1  TX clock; the FIFO read clock is driven from the same net
- RST  in  1  reset; synchronous, active-high
- fifo_empty  in  1  FIFO empty flag, already synchronised to CLK
- fifo_data  in  data_width  FIFO read data; valid while fifo_empty=0
- fifo_rinc  out  1  one-cycle pop pulse to the FIFO read-increment input
- par_en  in  1  1 = append a parity bit
- par_typ  in  1  0 = even parity, 1 = odd parity
- prescale  in  presc_width  CLK cycles per bit; 0 is treated as 1
- tx_out  out  1  serial line; idles high
- busy  out  1  high from the cycle after a pop until the frame ends
- frame_done  out  1  one-cycle pulse in the last cycle of each stop bit

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_out=1, busy=0.
  - If fifo_empty=0: assert fifo_rinc combinationally in the same cycle.
  - At that edge, capture fifo_data, par_en, par_typ and max(prescale,1) into shadow registers, then go to START.
- START: tx_out=0 for one bit period, then go to DATA.
- DATA:
  - Send the captured word LSB first; each bit lasts one bit period.
  - A bit index counter runs 0..data_width-1.
  - After the last bit: go to PARITY if the captured par_en=1, else STOP.
- PARITY: tx_out = ^data XOR captured par_typ, for one bit period.
- STOP: tx_out=1 for one bit period. In its last cycle, frame_done=1. At that point:
  - If fifo_empty=0: pop in the same cycle (fifo_rinc=1, capture as in IDLE) and go to START.
  - Otherwise go to IDLE.
- Bit-period counter:
  - Counts 0..P-1 using the captured P; the bit ends when counter = P-1.
  - Width is presc_width; it reloads to 0 on every state change.
- Config inputs are used only at pop time. Changing them mid-frame has no effect on the current frame.
- fifo_rinc is never asserted while fifo_empty=1, and never more than once per frame.

## Timing
- Reset values (next edge with RST=1): state=IDLE, tx_out=1, busy=0, fifo_rinc=0, frame_done=0, all counters 0.
- Reset mid-frame aborts the frame: tx_out returns high on the same edge, and the popped word is discarded.
- fifo_rinc is combinational from state, fifo_empty and the counter, so the FIFO advances at the same edge that captures the data.
- Latency: pop cycle T → tx_out falls at T+1.
- Frame length in CLK cycles: P × (1 + data_width + par_en + 1).
- Back-to-back: START of the next frame begins the cycle after frame_done; tx_out is never high between frames except during the stop bit.
- busy is registered and equals (state != IDLE).
- RST and fifo_empty=0 in the same cycle: reset wins and no pop occurs. fifo_rinc is gated by ~RST.

## Structure
- A shared UART package holds:
  - the state encoding (5 states, 3-bit binary);
  - parity-type constants PAR_EVEN=0, PAR_ODD=1;
  - default data_width and presc_width.
- One natural sub-module: uart_tx_bit_timer, which holds the bit-period counter and produces a bit_end strobe. It has a load input and a captured-prescale input.
- The FSM, the shift/index logic and the parity calculation stay in the top module.

## Test plan
- Reset, then check idle outputs: tx_out=1, busy=0, fifo_rinc=0; tx_out stays 1 for 20 cycles with fifo_empty=1.
- prescale=1, par_en=1, par_typ=0, present fifo_data=0xA5:
  - fifo_rinc pulses once;
  - tx_out reads 0,1,0,1,0,0,1,0,1,0,1;
  - frame_done pulses on the 11th bit.
- prescale=4, par_en=0, data 0x3C:
  - each bit is held exactly 4 cycles;
  - the frame lasts 40 cycles;
  - bits after start read 0,0,1,1,1,1,0,0 then stop.
- Two words queued (0x01, then 0xFF with odd parity, prescale=2):
  - the second pop coincides with the first frame_done;
  - the second start bit follows immediately with no idle cycle;
  - the second frame's parity bit = 1.
- Reset asserted at bit 3 of DATA:
  - tx_out=1 and state IDLE after the edge;
  - with fifo_empty=0 after reset release, the next pop starts a fresh frame.
- prescale=0 with par_typ toggled mid-frame:
  - the frame behaves as prescale=1;
  - parity matches the par_typ value sampled at pop time.
